conv_32_8: RTL and testbench



---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_shift_reg.sv | 36 +++
 rtl/conv_32_8.sv | 95 +++++++++
 tb/tb_conv_32_8.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the 32-to-8 width converter.
// State encoding, default widths and a width helper.
package conv_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/conv_shift_reg.sv
// Parallel-load shift register presenting one output byte at a time.
// MSB_FIRST selects which end of the word leaves first.
import conv_pkg::*;

module conv_shift_reg #(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] q_byte
);

  logic [IN_W-1:0] sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh <= '0;
    end else if (load) begin
      sh <= d;
    end else if (shift) begin
      if (MSB_FIRST)
        sh <= {sh[IN_W-OUT_W-1:0], {OUT_W{1'b0}}};
      else
        sh <= {{OUT_W{1'b0}}, sh[IN_W-1:OUT_W]};
    end
  end

  assign q_byte = MSB_FIRST ? sh[IN_W-1 -: OUT_W]
                            : sh[OUT_W-1:0];

endmodule

// File: rtl/conv_32_8.sv
// Word-to-byte serializer with a one-word holding buffer.
// Reloads on the last byte so back-to-back words stream gap-free.
import conv_pkg::*;

module conv_32_8 #(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             ready_in,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out
);

  localparam int N  = IN_W / OUT_W;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic             state;
  logic [CW-1:0]    cnt;
  logic [IN_W-1:0]  hold;
  logic             hold_v;
  logic             accept;
  logic             last;
  logic             load;
  logic             shift;
  logic [IN_W-1:0]  load_d;
  logic [OUT_W-1:0] q_byte;

  assign ready_in = !hold_v;
  assign accept   = valid_in && ready_in;
  assign last     = (state == ST_SEND) && (cnt == LAST);
  assign load     = ((state == ST_IDLE) && accept)
                 || (last && (hold_v || accept));
  assign shift    = (state == ST_SEND) && !last;
  // A held word always wins the reload; bypass only when hold is empty.
  assign load_d   = hold_v ? hold : data_in;
  assign data_out = valid_out ? q_byte : '0;

  conv_shift_reg #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .d      (load_d),
    .q_byte (q_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SEND;
            cnt       <= '0;
            valid_out <= 1'b1;
          end
        end
        ST_SEND: begin
          if (last) begin
            cnt <= '0;
            if (hold_v) begin
              hold_v <= 1'b0;
            end else if (!accept) begin
              state     <= ST_IDLE;
              valid_out <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (accept) begin
              hold   <= data_in;
              hold_v <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_32_8.sv
// Bench for conv_32_8: MSB-first and LSB-first builds against a byte-queue
// model, plus reassembly of the MSB-first stream back into words.
module tb_conv_32_8;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] data_in;

  logic        ready_m, valid_m;
  logic [7:0]  data_m;
  logic        ready_l, valid_l;
  logic [7:0]  data_l;

  logic [7:0]  q_m[$];
  logic [7:0]  q_l[$];
  logic [31:0] sent[$];
  logic [31:0] asm_w;
  int          nb;
  int          nvec;
  int          nerr;

  conv_32_8 #(.MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_m),
    .data_out  (data_m),
    .valid_out (valid_m)
  );

  conv_32_8 #(.MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_l),
    .data_out  (data_l),
    .valid_out (valid_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) q_m.push_back(w[i*8 +: 8]);
    for (int i = 0; i < 4; i++) q_l.push_back(w[i*8 +: 8]);
    sent.push_back(w);
  endfunction

  function automatic void flush_model();
    q_m.delete();
    q_l.delete();
    sent.delete();
    nb    = 0;
    asm_w = '0;
  endfunction

  // Called at a falling edge: check the byte on show, then advance one clock.
  task automatic tick(output bit acc);
    logic [7:0]  em, el;
    logic [31:0] d;
    em = (q_m.size() != 0) ? q_m[0] : 8'h00;
    el = (q_l.size() != 0) ? q_l[0] : 8'h00;
    chk("valid_m", 32'(valid_m), 32'(q_m.size() != 0));
    chk("data_m",  32'(data_m),  32'(em));
    chk("ready_m", 32'(ready_m), 32'(q_m.size() <= 4));
    chk("valid_l", 32'(valid_l), 32'(q_l.size() != 0));
    chk("data_l",  32'(data_l),  32'(el));
    chk("ready_l", 32'(ready_l), 32'(q_l.size() <= 4));
    if (valid_m) begin
      asm_w = {asm_w[23:0], data_m};
      nb++;
      if (nb == 4) begin
        nb = 0;
        chk("loop_word", asm_w,
            (sent.size() != 0) ? sent.pop_front() : ~asm_w);
      end
    end
    acc = valid_in && !reset && (q_m.size() <= 4);
    d   = data_in;
    @(posedge clk);
    if (reset) begin
      flush_model();
    end else begin
      if (q_m.size() != 0) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (acc) push_word(d);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    valid_in = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic offer(input logic [31:0] w, input bit keep);
    bit acc;
    int n;
    valid_in = 1'b1;
    data_in  = w;
    n        = 0;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 16);
    chk("accept_in_time", 32'(acc), 32'd1);
    if (!keep) valid_in = 1'b0;
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    nb       = 0;
    asm_w    = '0;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    @(negedge clk);

    // reset then a single word
    idle(2);
    reset = 1'b0;
    offer(32'hA1B2C3D4, 1'b0);
    idle(6);

    // one word every four cycles, aligned to the last byte
    offer(32'h01020304, 1'b0);
    idle(3);
    offer(32'h05060708, 1'b0);
    idle(3);
    offer(32'h090A0B0C, 1'b0);
    idle(6);

    // valid held high: second word waits in hold
    offer(32'h11111111, 1'b1);
    offer(32'h22222222, 1'b1);
    offer(32'h33333333, 1'b0);
    idle(14);

    // asynchronous reset while B2 is on the output
    offer(32'hA1B2C3D4, 1'b0);
    idle(1);
    #1 reset = 1'b1;
    #1;
    chk("rst_valid_m", 32'(valid_m), 32'd0);
    chk("rst_data_m",  32'(data_m),  32'd0);
    chk("rst_ready_m", 32'(ready_m), 32'd1);
    chk("rst_valid_l", 32'(valid_l), 32'd0);
    chk("rst_data_l",  32'(data_l),  32'd0);
    flush_model();
    #1 reset = 1'b0;
    @(negedge clk);
    idle(6);

    // random words with random hold-high and gaps
    for (int k = 0; k < 40; k++) begin
      offer($urandom, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 5));
    end
    idle(12);
    chk("all_words_out", 32'(sent.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
